// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Fills the byte-wide instruction memory from a serial byte stream at boot
//   and keeps the CPU stalled until a complete, checksum-verified frame has
//   been written.
//   Frame: 0xA5, 4-byte little-endian length L, L payload bytes, XOR checksum.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx_valid   rx_data holds a byte
//   rx_data    received byte
//   rx_ready   loader accepts a byte this cycle (decoded from state only)
//   mem_we     imem byte write strobe, one cycle per payload byte
//   mem_addr   imem byte address
//   mem_wdata  imem write data
//   cpu_hold   1 = CPU stalled, PC held at 0
//   load_done  frame loaded and checksum matched (sticky)
//   load_err   length, checksum or timeout error (sticky)
//
// state | meaning
// ------+------------------------------------------------------------
// SYNC  | hunting for 0xA5, other bytes dropped, no timeout
// LEN   | collecting the 4 length bytes, LSB first
// CHECK | one-cycle length range check, prepares payload counters
// DATA  | writing payload bytes to imem, folding them into the XOR
// CSUM  | comparing the checksum byte against the XOR accumulator
// DONE  | load complete, CPU released, terminal until reset
// ERR   | load failed, CPU held, terminal until reset

module imem_boot_loader #(
   parameter int MEM_BYTES   = 3200,
   parameter int ADDR_W      = 12,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int REM_W = $clog2(MEM_BYTES + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [31:0]      MAX_LEN  = 32'(MEM_BYTES);
   localparam logic [7:0]       SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_SYNC, S_LEN, S_CHECK, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t            state;
   logic [31:0]       len;
   logic [1:0]        len_cnt;
   logic [REM_W-1:0]  rem;
   logic [ADDR_W-1:0] addr_cnt;
   logic [7:0]        acc;
   logic [TMR_W-1:0]  tmr;
   logic              accept;
   logic              timed;

   assign rx_ready = (state == S_SYNC) || (state == S_LEN) ||
                     (state == S_DATA) || (state == S_CSUM);
   assign accept   = rx_valid & rx_ready;
   assign timed    = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);

   // tmr is a down-counter reloaded on every accepted byte; an idle cycle
   // that finds it at zero is the TIMEOUT_CYC-th consecutive idle cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_SYNC;
         len       <= '0;
         len_cnt   <= '0;
         rem       <= '0;
         addr_cnt  <= '0;
         acc       <= '0;
         tmr       <= TMR_LOAD;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         mem_we <= 1'b0;

         if (accept)
            tmr <= TMR_LOAD;
         else if (timed && (tmr != '0))
            tmr <= tmr - TMR_W'(1);

         case (state)
            S_SYNC: begin
               if (accept && (rx_data == SYNC_BYTE)) begin
                  len_cnt <= '0;
                  state   <= S_LEN;
               end
            end
            S_LEN: begin
               if (accept) begin
                  len     <= {rx_data, len[31:8]};
                  len_cnt <= len_cnt + 2'd1;
                  if (len_cnt == 2'd3)
                     state <= S_CHECK;
               end else if (tmr == '0) begin
                  load_err <= 1'b1;
                  state    <= S_ERR;
               end
            end
            S_CHECK: begin
               if ((len == '0) || (len > MAX_LEN)) begin
                  load_err <= 1'b1;
                  state    <= S_ERR;
               end else begin
                  // len fits in REM_W bits once the range check has passed
                  rem      <= len[REM_W-1:0];
                  addr_cnt <= '0;
                  acc      <= '0;
                  state    <= S_DATA;
               end
            end
            S_DATA: begin
               if (accept) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_cnt;
                  mem_wdata <= rx_data;
                  addr_cnt  <= addr_cnt + ADDR_W'(1);
                  acc       <= acc ^ rx_data;
                  rem       <= rem - REM_W'(1);
                  if (rem == REM_W'(1))
                     state <= S_CSUM;
               end else if (tmr == '0) begin
                  load_err <= 1'b1;
                  state    <= S_ERR;
               end
            end
            S_CSUM: begin
               if (accept) begin
                  if (rx_data == acc) begin
                     cpu_hold  <= 1'b0;
                     load_done <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     load_err <= 1'b1;
                     state    <= S_ERR;
                  end
               end else if (tmr == '0) begin
                  load_err <= 1'b1;
                  state    <= S_ERR;
               end
            end
            S_DONE: state <= S_DONE;
            S_ERR:  state <= S_ERR;
            default: begin
               load_err <= 1'b1;
               state    <= S_ERR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//   Directed bench for imem_boot_loader with TIMEOUT_CYC reduced to 16.
//   Frames are pushed into tx_q and streamed by send_q; a negedge monitor
//   records every imem write into mem_model.

module tb_imem_boot_loader;

   logic        clk;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int wr_cnt   = 0;
   int wr_last  = 0;
   int gap_bad  = 0;
   int hold_bad = 0;
   logic [7:0] mem_model [0:4095];
   logic [7:0] tx_q [$];

   imem_boot_loader #(
      .MEM_BYTES   (3200),
      .ADDR_W      (12),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         mem_model[mem_addr] = mem_wdata;
         if ((wr_cnt > 0) && (cyc != wr_last + 1)) gap_bad++;
         if (cpu_hold !== 1'b1) hold_bad++;
         wr_last = cyc;
         wr_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      wr_cnt   = 0;
      gap_bad  = 0;
      hold_bad = 0;
   endtask

   // Streams tx_q back to back; returns 1 time unit after the last accept edge.
   task automatic send_q();
      for (int i = 0; i < tx_q.size(); i++) begin
         int w;
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = tx_q[i];
         w = 0;
         while ((rx_ready !== 1'b1) && (w < 50)) begin
            @(negedge clk);
            w++;
         end
         if (rx_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL send_ready: byte %0d never accepted, rx_ready=%b", i, rx_ready);
            rx_valid = 1'b0;
            tx_q.delete();
            return;
         end
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b0;
      tx_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #3;
      n_checks++; if (rx_ready  !== 1'b1)  begin n_fail++; $display("FAIL reset_rx_ready: got %b exp 1", rx_ready); end
      n_checks++; if (mem_we    !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_we: got %b exp 0", mem_we); end
      n_checks++; if (mem_addr  !== 12'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h exp 000", mem_addr); end
      n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h exp 00", mem_wdata); end
      n_checks++; if (cpu_hold  !== 1'b1)  begin n_fail++; $display("FAIL reset_cpu_hold: got %b exp 1", cpu_hold); end
      n_checks++; if (load_done !== 1'b0)  begin n_fail++; $display("FAIL reset_load_done: got %b exp 0", load_done); end
      n_checks++; if (load_err  !== 1'b0)  begin n_fail++; $display("FAIL reset_load_err: got %b exp 0", load_err); end
      do_reset();
   endtask

   task automatic test_basic_load();
      do_reset();
      tx_q = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      send_q();
      @(negedge clk);
      n_checks++; if (wr_cnt != 4) begin n_fail++; $display("FAIL basic_writes: got %0d exp 4", wr_cnt); end
      n_checks++; if (mem_model[0] !== 8'h13) begin n_fail++; $display("FAIL basic_mem0: got %h exp 13", mem_model[0]); end
      n_checks++; if (mem_model[1] !== 8'h00) begin n_fail++; $display("FAIL basic_mem1: got %h exp 00", mem_model[1]); end
      n_checks++; if (mem_model[2] !== 8'h00) begin n_fail++; $display("FAIL basic_mem2: got %h exp 00", mem_model[2]); end
      n_checks++; if (mem_model[3] !== 8'h00) begin n_fail++; $display("FAIL basic_mem3: got %h exp 00", mem_model[3]); end
      n_checks++; if (gap_bad != 0) begin n_fail++; $display("FAIL basic_back_to_back: got %0d gaps exp 0", gap_bad); end
      n_checks++; if (hold_bad != 0) begin n_fail++; $display("FAIL basic_hold_during_write: got %0d exp 0", hold_bad); end
      n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL basic_load_done: got %b exp 1", load_done); end
      n_checks++; if (cpu_hold  !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_hold: got %b exp 0", cpu_hold); end
      n_checks++; if (load_err  !== 1'b0) begin n_fail++; $display("FAIL basic_load_err: got %b exp 0", load_err); end
      n_checks++; if (rx_ready  !== 1'b0) begin n_fail++; $display("FAIL basic_rx_ready: got %b exp 0", rx_ready); end
   endtask

   task automatic test_bad_checksum();
      do_reset();
      tx_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h00};
      send_q();
      @(negedge clk);
      n_checks++; if (wr_cnt != 2) begin n_fail++; $display("FAIL csum_writes: got %0d exp 2", wr_cnt); end
      n_checks++; if (mem_model[0] !== 8'hAA) begin n_fail++; $display("FAIL csum_mem0: got %h exp AA", mem_model[0]); end
      n_checks++; if (mem_model[1] !== 8'h55) begin n_fail++; $display("FAIL csum_mem1: got %h exp 55", mem_model[1]); end
      n_checks++; if (load_err  !== 1'b1) begin n_fail++; $display("FAIL csum_load_err: got %b exp 1", load_err); end
      n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL csum_load_done: got %b exp 0", load_done); end
      n_checks++; if (cpu_hold  !== 1'b1) begin n_fail++; $display("FAIL csum_cpu_hold: got %b exp 1", cpu_hold); end
      n_checks++; if (rx_ready  !== 1'b0) begin n_fail++; $display("FAIL csum_rx_ready: got %b exp 0", rx_ready); end
   endtask

   task automatic test_resync();
      do_reset();
      mem_model[0] = 8'h00;
      tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h7E, 8'h7E};
      send_q();
      @(negedge clk);
      n_checks++; if (wr_cnt != 1) begin n_fail++; $display("FAIL resync_writes: got %0d exp 1", wr_cnt); end
      n_checks++; if (mem_model[0] !== 8'h7E) begin n_fail++; $display("FAIL resync_mem0: got %h exp 7E", mem_model[0]); end
      n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL resync_load_done: got %b exp 1", load_done); end
      n_checks++; if (cpu_hold  !== 1'b0) begin n_fail++; $display("FAIL resync_cpu_hold: got %b exp 0", cpu_hold); end
   endtask

   task automatic test_bad_length();
      // 0x00000C81 = 3201, one past the memory size
      do_reset();
      tx_q = '{8'hA5, 8'h81, 8'h0C, 8'h00, 8'h00};
      send_q();
      @(negedge clk);
      n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL len3201_check_ready: got %b exp 0", rx_ready); end
      n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL len3201_err_early: got %b exp 0", load_err); end
      @(negedge clk);
      n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL len3201_load_err: got %b exp 1", load_err); end
      repeat (3) @(negedge clk);
      n_checks++; if (wr_cnt != 0) begin n_fail++; $display("FAIL len3201_writes: got %0d exp 0", wr_cnt); end

      do_reset();
      tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
      send_q();
      repeat (2) @(negedge clk);
      n_checks++; if (load_err  !== 1'b1) begin n_fail++; $display("FAIL len0_load_err: got %b exp 1", load_err); end
      n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL len0_load_done: got %b exp 0", load_done); end
      repeat (3) @(negedge clk);
      n_checks++; if (wr_cnt != 0) begin n_fail++; $display("FAIL len0_writes: got %0d exp 0", wr_cnt); end
   endtask

   task automatic test_max_length();
      // L = 3200 = 0x0C80, payload byte i = i[7:0]; XOR of those bytes is 00
      do_reset();
      tx_q = '{8'hA5, 8'h80, 8'h0C, 8'h00, 8'h00};
      for (int i = 0; i < 3200; i++) tx_q.push_back(8'(i));
      tx_q.push_back(8'h00);
      send_q();
      @(negedge clk);
      n_checks++; if (wr_cnt != 3200) begin n_fail++; $display("FAIL max_writes: got %0d exp 3200", wr_cnt); end
      n_checks++; if (mem_model[3199] !== 8'h7F) begin n_fail++; $display("FAIL max_mem3199: got %h exp 7F", mem_model[3199]); end
      n_checks++; if (mem_model[256] !== 8'h00) begin n_fail++; $display("FAIL max_mem256: got %h exp 00", mem_model[256]); end
      n_checks++; if (gap_bad != 0) begin n_fail++; $display("FAIL max_back_to_back: got %0d gaps exp 0", gap_bad); end
      n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL max_load_done: got %b exp 1", load_done); end
      n_checks++; if (load_err  !== 1'b0) begin n_fail++; $display("FAIL max_load_err: got %b exp 0", load_err); end
   endtask

   task automatic test_timeout();
      do_reset();
      tx_q = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
      send_q();
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 15) begin
            n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: idle %0d got %b exp 0", k, load_err); end
         end
         if (k == 16) begin
            n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL timeout_fire: idle %0d got %b exp 1", k, load_err); end
         end
      end
      n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL timeout_cpu_hold: got %b exp 1", cpu_hold); end
      tx_q = '{8'h33};
      rx_valid = 1'b1;
      rx_data  = 8'h33;
      repeat (5) @(negedge clk);
      rx_valid = 1'b0;
      tx_q.delete();
      n_checks++; if (wr_cnt != 2) begin n_fail++; $display("FAIL timeout_writes: got %0d exp 2", wr_cnt); end
      n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_rx_ready: got %b exp 0", rx_ready); end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      tx_q = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
      send_q();
      #1;
      rst = 1'b1;
      #1;
      n_checks++; if (mem_we    !== 1'b0)  begin n_fail++; $display("FAIL midrst_mem_we: got %b exp 0", mem_we); end
      n_checks++; if (mem_addr  !== 12'h0) begin n_fail++; $display("FAIL midrst_mem_addr: got %h exp 000", mem_addr); end
      n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL midrst_mem_wdata: got %h exp 00", mem_wdata); end
      n_checks++; if (rx_ready  !== 1'b1)  begin n_fail++; $display("FAIL midrst_rx_ready: got %b exp 1", rx_ready); end
      n_checks++; if (cpu_hold  !== 1'b1)  begin n_fail++; $display("FAIL midrst_cpu_hold: got %b exp 1", cpu_hold); end
      n_checks++; if (load_err  !== 1'b0)  begin n_fail++; $display("FAIL midrst_load_err: got %b exp 0", load_err); end
      do_reset();
      tx_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'hC3, 8'h3C, 8'hFF};
      send_q();
      @(negedge clk);
      n_checks++; if (wr_cnt != 2) begin n_fail++; $display("FAIL fresh_writes: got %0d exp 2", wr_cnt); end
      n_checks++; if (mem_model[0] !== 8'hC3) begin n_fail++; $display("FAIL fresh_mem0: got %h exp C3", mem_model[0]); end
      n_checks++; if (mem_model[1] !== 8'h3C) begin n_fail++; $display("FAIL fresh_mem1: got %h exp 3C", mem_model[1]); end
      n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL fresh_load_done: got %b exp 1", load_done); end
      n_checks++; if (cpu_hold  !== 1'b0) begin n_fail++; $display("FAIL fresh_cpu_hold: got %b exp 0", cpu_hold); end
   endtask

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      test_reset();
      test_basic_load();
      test_bad_checksum();
      test_resync();
      test_bad_length();
      test_max_length();
      test_timeout();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
